ps2_key_event: RTL and testbench

//  Consumes raw scan-code bytes from ps2_keyboard through its ready/nextdata_n FIFO handshake.

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_scan2ascii.sv | 61 ++++++
 rtl/ps2_key_event.sv | 144 ++++++++++++++
 tb/tb_ps2_key_event.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared scan-code constants and state encodings for the PS/2 key-event decoder.
package ps2_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    typedef enum logic [1:0] {
        P_NONE,
        P_EXT,
        P_BRK,
        P_EXT_BRK
    } pfx_t;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } fetch_t;

endpackage

// File: rtl/ps2_scan2ascii.sv
// Set-2 scan code to ASCII lookup; letters are case-folded by 'upper', extended codes map to 00.
module ps2_scan2ascii (
    input  logic [7:0] code,
    input  logic       ext,
    input  logic       upper,
    output logic [7:0] ascii
);

    logic [7:0] lower;

    always_comb begin
        lower = 8'h00;
        ascii = 8'h00;
        case (code)
            8'h1C: lower = 8'h61;
            8'h32: lower = 8'h62;
            8'h21: lower = 8'h63;
            8'h23: lower = 8'h64;
            8'h24: lower = 8'h65;
            8'h2B: lower = 8'h66;
            8'h34: lower = 8'h67;
            8'h33: lower = 8'h68;
            8'h43: lower = 8'h69;
            8'h3B: lower = 8'h6A;
            8'h42: lower = 8'h6B;
            8'h4B: lower = 8'h6C;
            8'h3A: lower = 8'h6D;
            8'h31: lower = 8'h6E;
            8'h44: lower = 8'h6F;
            8'h4D: lower = 8'h70;
            8'h15: lower = 8'h71;
            8'h2D: lower = 8'h72;
            8'h1B: lower = 8'h73;
            8'h2C: lower = 8'h74;
            8'h3C: lower = 8'h75;
            8'h2A: lower = 8'h76;
            8'h1D: lower = 8'h77;
            8'h22: lower = 8'h78;
            8'h35: lower = 8'h79;
            8'h1A: lower = 8'h7A;
            8'h45: ascii = 8'h30;
            8'h16: ascii = 8'h31;
            8'h1E: ascii = 8'h32;
            8'h26: ascii = 8'h33;
            8'h25: ascii = 8'h34;
            8'h2E: ascii = 8'h35;
            8'h36: ascii = 8'h36;
            8'h3D: ascii = 8'h37;
            8'h3E: ascii = 8'h38;
            8'h46: ascii = 8'h39;
            8'h29: ascii = 8'h20;
            8'h5A: ascii = 8'h0D;
            8'h66: ascii = 8'h08;
            default: ;
        endcase
        // Letters differ from their capitals only in bit 5.
        if (lower != 8'h00) ascii = upper ? (lower ^ 8'h20) : lower;
        if (ext) ascii = 8'h00;
    end

endmodule

// File: rtl/ps2_key_event.sv
// Pops scan-code bytes from ps2_keyboard, folds E0/F0 prefixes into single key events,
// and tracks the held key, shift/caps state and new-press count.
import ps2_pkg::*;

module ps2_key_event #(
    parameter int COUNT_W    = 8,
    parameter bit REPEAT_EVT = 1'b1
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic               ready,
    input  logic [7:0]         data,
    input  logic               overflow,
    output logic               nextdata_n,
    output logic               key_valid,
    output logic [7:0]         key_code,
    output logic               key_ext,
    output logic               key_break,
    output logic               key_repeat,
    output logic [7:0]         key_ascii,
    output logic               key_held,
    output logic [COUNT_W-1:0] press_count,
    output logic               shift_on,
    output logic               caps_on,
    output logic               err_ovf
);

    fetch_t     state, state_nxt;
    pfx_t       pfx, pfx_nxt;
    logic       pop;
    logic [8:0] held_q;
    logic       shift_l, shift_r, caps_down;

    logic       ev_ext, ev_brk, is_final;
    logic       is_lsh, is_rsh, is_caps, is_mod;
    logic       held_match, rep, rep_make, emit;
    logic [7:0] ascii_raw, ev_ascii;

    // Gating with clrn keeps the pop strobe idle while reset is asserted.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE: if (ready && clrn) begin
                pop       = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign nextdata_n = ~pop;

    // Malformed prefix runs collapse onto the rule for the latest prefix byte.
    always_comb begin
        pfx_nxt = pfx;
        if (pop) begin
            if (data == SC_EXT)      pfx_nxt = P_EXT;
            else if (data == SC_BRK) pfx_nxt = (pfx == P_EXT) ? P_EXT_BRK : P_BRK;
            else                     pfx_nxt = P_NONE;
        end
    end

    always_comb begin
        ev_ext     = (pfx == P_EXT) || (pfx == P_EXT_BRK);
        ev_brk     = (pfx == P_BRK) || (pfx == P_EXT_BRK);
        is_final   = pop && (data != SC_EXT) && (data != SC_BRK);
        is_lsh     = !ev_ext && (data == SC_LSHIFT);
        is_rsh     = !ev_ext && (data == SC_RSHIFT);
        is_caps    = !ev_ext && (data == SC_CAPS);
        is_mod     = is_lsh || is_rsh || is_caps;
        held_match = key_held && (held_q == {ev_ext, data});
        if (is_lsh)       rep = shift_l;
        else if (is_rsh)  rep = shift_r;
        else if (is_caps) rep = caps_down;
        else              rep = held_match;
        rep_make   = !ev_brk && rep;
        emit       = is_final && (!rep_make || REPEAT_EVT);
        ev_ascii   = ev_brk ? 8'h00 : ascii_raw;
    end

    ps2_scan2ascii u_scan2ascii (
        .code  (data),
        .ext   (ev_ext),
        .upper (shift_on ^ caps_on),
        .ascii (ascii_raw)
    );

    assign shift_on = shift_l | shift_r;

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state       <= S_IDLE;
            pfx         <= P_NONE;
            key_valid   <= 1'b0;
            key_code    <= 8'h00;
            key_ext     <= 1'b0;
            key_break   <= 1'b0;
            key_repeat  <= 1'b0;
            key_ascii   <= 8'h00;
            key_held    <= 1'b0;
            held_q      <= 9'h000;
            press_count <= '0;
            shift_l     <= 1'b0;
            shift_r     <= 1'b0;
            caps_down   <= 1'b0;
            caps_on     <= 1'b0;
            err_ovf     <= 1'b0;
        end else begin
            state     <= state_nxt;
            pfx       <= pfx_nxt;
            key_valid <= emit;
            if (overflow) err_ovf <= 1'b1;
            if (emit) begin
                key_code   <= data;
                key_ext    <= ev_ext;
                key_break  <= ev_brk;
                key_repeat <= rep_make;
                key_ascii  <= ev_ascii;
            end
            if (is_final) begin
                if (is_lsh) shift_l <= !ev_brk;
                if (is_rsh) shift_r <= !ev_brk;
                if (is_caps) begin
                    caps_down <= !ev_brk;
                    if (!ev_brk && !caps_down) caps_on <= !caps_on;
                end
                if (!is_mod) begin
                    if (!ev_brk) begin
                        if (!held_match) begin
                            held_q      <= {ev_ext, data};
                            key_held    <= 1'b1;
                            press_count <= press_count + 1'b1;
                        end
                    end else if (held_match) begin
                        key_held <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_event.sv
// Directed bench: a queue stands in for the ps2_keyboard FIFO; key events are logged and
// compared against hand-derived values.
module tb_ps2_key_event;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       ready = 1'b0;
    logic [7:0] data = 8'h00;
    logic       overflow = 1'b0;

    logic       nextdata_n, key_valid, key_ext, key_break, key_repeat, key_held;
    logic       shift_on, caps_on, err_ovf;
    logic [7:0] key_code, key_ascii, press_count;

    logic       nextdata_n1, key_valid1, key_ext1, key_break1, key_repeat1, key_held1;
    logic       shift_on1, caps_on1, err_ovf1;
    logic [7:0] key_code1, key_ascii1;
    logic [1:0] press_count1;

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic       rep;
        logic [7:0] ascii;
    } ev_t;

    ev_t        evq[$];
    logic [7:0] fifo[$];
    int         n_ev1 = 0;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    ps2_key_event #(.COUNT_W(8), .REPEAT_EVT(1'b1)) dut (
        .clk(clk), .clrn(clrn), .ready(ready), .data(data), .overflow(overflow),
        .nextdata_n(nextdata_n), .key_valid(key_valid), .key_code(key_code),
        .key_ext(key_ext), .key_break(key_break), .key_repeat(key_repeat),
        .key_ascii(key_ascii), .key_held(key_held), .press_count(press_count),
        .shift_on(shift_on), .caps_on(caps_on), .err_ovf(err_ovf)
    );

    // Narrow counter, repeats suppressed; runs in lockstep with dut on the same byte stream.
    ps2_key_event #(.COUNT_W(2), .REPEAT_EVT(1'b0)) dut_norep (
        .clk(clk), .clrn(clrn), .ready(ready), .data(data), .overflow(overflow),
        .nextdata_n(nextdata_n1), .key_valid(key_valid1), .key_code(key_code1),
        .key_ext(key_ext1), .key_break(key_break1), .key_repeat(key_repeat1),
        .key_ascii(key_ascii1), .key_held(key_held1), .press_count(press_count1),
        .shift_on(shift_on1), .caps_on(caps_on1), .err_ovf(err_ovf1)
    );

    always @(posedge clk) begin
        if (!nextdata_n && ready && fifo.size() != 0) fifo.delete(0);
        #1;
        ready = (fifo.size() != 0);
        data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    end

    always @(negedge clk) begin
        if (key_valid) evq.push_back('{key_code, key_ext, key_break, key_repeat, key_ascii});
        if (key_valid1) n_ev1++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        clrn = 1'b0;
        fifo.delete();
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        evq.delete();
        n_ev1 = 0;
    endtask

    task automatic send(input logic [7:0] b[$]);
        foreach (b[i]) fifo.push_back(b[i]);
    endtask

    task automatic drain();
        int k = 0;
        while (fifo.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (fifo.size() != 0) check("drain_timeout", 32'd1, 32'd0);
        repeat (4) @(negedge clk);
    endtask

    function automatic ev_t ev(input int i);
        ev_t e = '{8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
        if (i < evq.size()) e = evq[i];
        return e;
    endfunction

    initial begin
        // Reset state, with a byte offered while clrn is low: it must not be popped.
        @(negedge clk);
        fifo.push_back(8'h1C);
        @(negedge clk);
        check("rst_nextdata_n", nextdata_n, 1'b1);
        fifo.delete();
        @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        check("rst_outs", {key_valid, key_code, key_ext, key_break, key_repeat, key_ascii,
                           key_held, press_count, shift_on, caps_on, err_ovf}, 32'd0);
        check("rst_nextdata_idle", nextdata_n, 1'b1);

        // 1: make then break of 'a'
        do_reset();
        send('{8'h1C});
        drain();
        check("t1_ev_n_make", evq.size(), 1);
        check("t1_make", {ev(0).code, ev(0).ext, ev(0).brk, ev(0).rep, ev(0).ascii}, {8'h1C, 3'b000, 8'h61});
        check("t1_held_make", key_held, 1'b1);
        check("t1_count_make", press_count, 8'd1);
        send('{8'hF0, 8'h1C});
        drain();
        check("t1_ev_n", evq.size(), 2);
        check("t1_break", {ev(1).code, ev(1).ext, ev(1).brk, ev(1).rep, ev(1).ascii}, {8'h1C, 3'b010, 8'h00});
        check("t1_held_brk", key_held, 1'b0);
        check("t1_count_brk", press_count, 8'd1);

        // 2: shifted 'A'
        do_reset();
        send('{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12});
        drain();
        check("t2_ev_n", evq.size(), 4);
        check("t2_shift_ev", {ev(0).code, ev(0).ascii}, {8'h12, 8'h00});
        check("t2_ascii", {ev(1).code, ev(1).ascii}, {8'h1C, 8'h41});
        check("t2_shift_end", shift_on, 1'b0);
        check("t2_count", press_count, 8'd1);

        // 3: typematic repeats
        do_reset();
        send('{8'h1C, 8'h1C, 8'h1C});
        drain();
        check("t3_ev_n", evq.size(), 3);
        check("t3_reps", {ev(0).rep, ev(1).rep, ev(2).rep}, 3'b011);
        check("t3_rep_ascii", ev(2).ascii, 8'h61);
        check("t3_count", press_count, 8'd1);
        check("t3_norep_ev_n", n_ev1, 1);
        check("t3_norep_count", press_count1, 2'd1);

        // 4: extended make/break
        do_reset();
        send('{8'hE0, 8'h75});
        drain();
        check("t4_held_make", key_held, 1'b1);
        send('{8'hE0, 8'hF0, 8'h75});
        drain();
        check("t4_ev_n", evq.size(), 2);
        check("t4_make", {ev(0).code, ev(0).ext, ev(0).brk, ev(0).ascii}, {8'h75, 2'b10, 8'h00});
        check("t4_break", {ev(1).code, ev(1).ext, ev(1).brk, ev(1).ascii}, {8'h75, 2'b11, 8'h00});
        check("t4_held_brk", key_held, 1'b0);

        // 5: caps lock, then caps+shift
        do_reset();
        send('{8'h58, 8'hF0, 8'h58, 8'h1C});
        drain();
        check("t5_caps", caps_on, 1'b1);
        check("t5_ascii_caps", ev(2).ascii, 8'h41);
        send('{8'hF0, 8'h1C, 8'h12, 8'h1C});
        drain();
        check("t5_ascii_caps_shift", {ev(5).code, ev(5).ascii}, {8'h1C, 8'h61});
        send('{8'h58, 8'h58, 8'hF0, 8'h58});
        drain();
        check("t5_caps_repeat_no_toggle", caps_on, 1'b0);

        // 6: reset mid-sequence, overflow flag
        do_reset();
        send('{8'hF0});
        drain();
        clrn = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
        send('{8'h1C});
        drain();
        check("t6_ev_n", evq.size(), 1);
        check("t6_not_break", ev(0).brk, 1'b0);
        check("t6_count", press_count, 8'd1);
        overflow = 1'b1;
        @(negedge clk);
        overflow = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_ovf_sticky", err_ovf, 1'b1);
        do_reset();
        check("t6_ovf_cleared", err_ovf, 1'b0);

        // 7: distinct presses, narrow counter wrap
        send('{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24});
        drain();
        check("t7_count", press_count, 8'd5);
        check("t7_count_wrap", press_count1, 2'd1);
        check("t7_ascii_e", ev(4).ascii, 8'h65);

        // 8: malformed prefixes, digits and space
        do_reset();
        send('{8'hF0, 8'hF0, 8'h1C});
        drain();
        check("t8_dbl_brk", {ev(0).code, ev(0).ext, ev(0).brk}, {8'h1C, 2'b01});
        check("t8_dbl_brk_held", key_held, 1'b0);
        send('{8'hE0, 8'hF0, 8'hE0, 8'h75});
        drain();
        check("t8_ext_reenter", {ev(1).code, ev(1).ext, ev(1).brk}, {8'h75, 2'b10});
        check("t8_ext_held", key_held, 1'b1);
        send('{8'h16, 8'h29, 8'h5A});
        drain();
        check("t8_ascii_1", ev(2).ascii, 8'h31);
        check("t8_ascii_sp", ev(3).ascii, 8'h20);
        check("t8_ascii_cr", ev(4).ascii, 8'h0D);
        check("t8_count", press_count, 8'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
